// File: rtl/udp_srio_width_packer_if.sv
// udp_srio_width_packer_if
//   Bundles the UDP-side beat stream, the SRIO-side word stream and the
//   error pulses of udp_srio_width_packer.
//   Ports (signals):
//     udp_data_in/keep_in/valid_in/first_in/last_in/length_in : input beats
//     udp_ready_out                                            : beat backpressure
//     srio_ready_in                                            : downstream ready
//     srio_data_out/keep_out/valid_out/first_out/last_out/length_out : packed words
//     nwr_req_out, proto_err_out, len_err_out                  : status pulses
//   Modports: slave = the packer's view, master = the environment's view.
interface udp_srio_width_packer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 64
);
  logic [IN_WIDTH-1:0]    udp_data_in;
  logic [IN_WIDTH/8-1:0]  udp_keep_in;
  logic                   udp_valid_in;
  logic                   udp_first_in;
  logic                   udp_last_in;
  logic [15:0]            udp_length_in;
  logic                   udp_ready_out;
  logic                   srio_ready_in;
  logic [OUT_WIDTH-1:0]   srio_data_out;
  logic [OUT_WIDTH/8-1:0] srio_keep_out;
  logic                   srio_valid_out;
  logic                   srio_first_out;
  logic                   srio_last_out;
  logic [15:0]            srio_length_out;
  logic                   nwr_req_out;
  logic                   proto_err_out;
  logic                   len_err_out;

  modport slave (
    input  udp_data_in, udp_keep_in, udp_valid_in, udp_first_in, udp_last_in,
           udp_length_in, srio_ready_in,
    output udp_ready_out, srio_data_out, srio_keep_out, srio_valid_out,
           srio_first_out, srio_last_out, srio_length_out, nwr_req_out,
           proto_err_out, len_err_out
  );

  modport master (
    output udp_data_in, udp_keep_in, udp_valid_in, udp_first_in, udp_last_in,
           udp_length_in, srio_ready_in,
    input  udp_ready_out, srio_data_out, srio_keep_out, srio_valid_out,
           srio_first_out, srio_last_out, srio_length_out, nwr_req_out,
           proto_err_out, len_err_out
  );
endinterface

// File: rtl/udp_srio_width_packer.sv
// udp_srio_width_packer
//   Packs N = OUT_WIDTH/IN_WIDTH UDP beats into one SRIO word (first beat in
//   the MSB lane), queues words in a first-word-fall-through FIFO and flags
//   framing and declared-length errors.
//   Ports:
//     clk_srio   : sole clock, rising edge
//     reset_srio : asynchronous active-high reset
//     bus        : udp_srio_width_packer_if.slave (beat in, word out, errors)
module udp_srio_width_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input logic                    clk_srio,
  input logic                    reset_srio,
  udp_srio_width_packer_if.slave bus
);
  localparam int N      = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(N);
  localparam int KIN    = IN_WIDTH / 8;
  localparam int KOUT   = OUT_WIDTH / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = OUT_WIDTH + KOUT + 2 + 16;

  function automatic logic [16:0] popcount(input logic [KIN-1:0] k);
    logic [16:0] s;
    s = '0;
    for (int i = 0; i < KIN; i++) s = s + 17'(k[i]);
    return s;
  endfunction

  logic [LANE_W-1:0]    lane_p0;
  logic [OUT_WIDTH-1:0] word_data_p0;
  logic [KOUT-1:0]      word_keep_p0;
  logic                 word_first_p0;
  logic [15:0]          pkt_len_p0;
  logic [16:0]          byte_cnt_p0;
  logic                 in_pkt;
  logic                 proto_err_p1;
  logic                 len_err_p1;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;

  logic fifo_full, fifo_empty, conflict, flush, accept;
  logic start_beat, cont_beat, stray_beat, word_done, push, pop;
  logic [LANE_W-1:0]    beat_lane;
  logic [OUT_WIDTH-1:0] cur_data;
  logic [KOUT-1:0]      cur_keep;
  logic [15:0]          len_used;
  logic [16:0]          byte_sum;
  logic [EW-1:0]        push_entry, head;
  logic [OUT_WIDTH-1:0] hd_data;
  logic [KOUT-1:0]      hd_keep;
  logic                 hd_first, hd_last;
  logic [15:0]          hd_len;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A new first beat on top of a half-filled word: close the old word with
  // last=1 this cycle and hold the new beat off until the next one.
  assign conflict = bus.udp_valid_in & bus.udp_first_in & in_pkt & (lane_p0 != '0);
  assign flush    = conflict & ~fifo_full;

  assign bus.udp_ready_out = ~fifo_full & ~conflict;
  assign accept     = bus.udp_valid_in & bus.udp_ready_out;
  assign start_beat = accept & bus.udp_first_in;
  assign cont_beat  = accept & ~bus.udp_first_in & in_pkt;
  assign stray_beat = accept & ~bus.udp_first_in & ~in_pkt;

  assign beat_lane = start_beat ? '0 : lane_p0;
  assign len_used  = start_beat ? bus.udp_length_in : pkt_len_p0;
  assign byte_sum  = (start_beat ? 17'd0 : byte_cnt_p0) + popcount(bus.udp_keep_in);

  always_comb begin
    cur_data = start_beat ? '0 : word_data_p0;
    cur_keep = start_beat ? '0 : word_keep_p0;
    for (int k = 0; k < N; k++) begin
      if (beat_lane == LANE_W'(k)) begin
        cur_data[OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] = bus.udp_data_in;
        cur_keep[KOUT-1-k*KIN -: KIN]               = bus.udp_keep_in;
      end
    end
  end

  assign word_done = (start_beat | cont_beat) &
                     ((beat_lane == LANE_W'(N-1)) | bus.udp_last_in);
  assign push = flush | word_done;
  assign push_entry = flush ?
    {word_data_p0, word_keep_p0, word_first_p0, 1'b1, pkt_len_p0} :
    {cur_data, cur_keep, start_beat | word_first_p0, bus.udp_last_in, len_used};

  // Stage p0: lane assembly and packet control
  always_ff @(posedge clk_srio or posedge reset_srio) begin
    if (reset_srio) begin
      lane_p0       <= '0;
      word_first_p0 <= 1'b0;
      in_pkt        <= 1'b0;
      byte_cnt_p0   <= '0;
      proto_err_p1  <= 1'b0;
      len_err_p1    <= 1'b0;
    end else begin
      proto_err_p1 <= flush | (start_beat & in_pkt) | stray_beat;
      len_err_p1   <= (start_beat | cont_beat) & bus.udp_last_in &
                      (byte_sum != {1'b0, len_used});
      if (start_beat | cont_beat) byte_cnt_p0 <= byte_sum;
      if (flush | word_done) begin
        lane_p0       <= '0;
        word_first_p0 <= 1'b0;
      end else if (start_beat | cont_beat) begin
        lane_p0       <= beat_lane + LANE_W'(1);
        word_first_p0 <= start_beat | word_first_p0;
      end
      if (flush)                              in_pkt <= 1'b0;
      else if (start_beat)                    in_pkt <= ~bus.udp_last_in;
      else if (cont_beat & bus.udp_last_in)   in_pkt <= 1'b0;
    end
  end

  always_ff @(posedge clk_srio) begin
    if (flush | word_done) begin
      word_data_p0 <= '0;
      word_keep_p0 <= '0;
    end else if (start_beat | cont_beat) begin
      word_data_p0 <= cur_data;
      word_keep_p0 <= cur_keep;
    end
    if (start_beat) pkt_len_p0 <= bus.udp_length_in;
    if (push)       mem[wr_ptr] <= push_entry;
  end

  // Stage p1: output FIFO pointers and occupancy
  assign pop = bus.srio_valid_out & bus.srio_ready_in;

  always_ff @(posedge clk_srio or posedge reset_srio) begin
    if (reset_srio) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign {hd_data, hd_keep, hd_first, hd_last, hd_len} = head;

  // Reset gates the outputs directly so they drop without a clock edge.
  assign bus.srio_valid_out  = ~fifo_empty & ~reset_srio;
  assign bus.srio_data_out   = bus.srio_valid_out ? hd_data : '0;
  assign bus.srio_keep_out   = bus.srio_valid_out ? hd_keep : '0;
  assign bus.srio_first_out  = bus.srio_valid_out & hd_first;
  assign bus.srio_last_out   = bus.srio_valid_out & hd_last;
  assign bus.srio_length_out = bus.srio_valid_out ? hd_len : '0;
  assign bus.nwr_req_out     = bus.srio_valid_out & hd_first;
  assign bus.proto_err_out   = proto_err_p1 & ~reset_srio;
  assign bus.len_err_out     = len_err_p1 & ~reset_srio;
endmodule

// File: tb/tb_udp_srio_width_packer.sv
// tb_udp_srio_width_packer
//   Directed bench for udp_srio_width_packer (32 -> 64 bits, 16-entry FIFO).
//   Expected words go into a queue as stimulus is issued; a monitor pops and
//   compares every word the DUT hands downstream and counts error pulses.
module tb_udp_srio_width_packer;
  localparam int IW = 32, OW = 64, DEPTH = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        first;
    logic        last;
    logic [15:0] len;
  } word_t;

  logic clk_srio, reset_srio;
  udp_srio_width_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  udp_srio_width_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_srio   (clk_srio),
    .reset_srio (reset_srio),
    .bus        (bus.slave)
  );

  initial clk_srio = 1'b0;
  always #5 clk_srio = ~clk_srio;

  word_t exp_q[$];
  word_t e;
  logic  bad;
  int checks = 0, errors = 0;
  int proto_cnt = 0, len_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [63:0] d, input logic [7:0] k,
                             input logic f, input logic l, input logic [15:0] len);
    word_t w;
    w.data = d; w.keep = k; w.first = f; w.last = l; w.len = len;
    exp_q.push_back(w);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_srio) begin
    if (bus.proto_err_out) proto_cnt++;
    if (bus.len_err_out)   len_cnt++;
    if (bus.srio_valid_out && bus.srio_ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h keep=%h, want no word",
                 bus.srio_data_out, bus.srio_keep_out);
      end else begin
        e = exp_q.pop_front();
        bad = (bus.srio_data_out !== e.data) || (bus.srio_keep_out !== e.keep) ||
              (bus.srio_first_out !== e.first) || (bus.srio_last_out !== e.last) ||
              (bus.nwr_req_out !== e.first) ||
              (e.first && (bus.srio_length_out !== e.len));
        if (bad) begin
          errors++;
          $display("FAIL word: got data=%h keep=%h first=%b last=%b len=%0d nwr=%b want data=%h keep=%h first=%b last=%b len=%0d",
                   bus.srio_data_out, bus.srio_keep_out, bus.srio_first_out,
                   bus.srio_last_out, bus.srio_length_out, bus.nwr_req_out,
                   e.data, e.keep, e.first, e.last, e.len);
        end
      end
    end
  end

  // Presents a beat and returns one cycle after it is accepted (edge + 1).
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic f,
                      input logic l, input logic [15:0] len, output int waits);
    bus.udp_data_in   = d;
    bus.udp_keep_in   = k;
    bus.udp_first_in  = f;
    bus.udp_last_in   = l;
    bus.udp_length_in = len;
    bus.udp_valid_in  = 1'b1;
    waits = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_srio);
      if (bus.udp_ready_out) begin
        @(posedge clk_srio); #1;
        return;
      end
      waits++;
    end
    checks++; errors++;
    $display("FAIL send_timeout: ready=0 for 300 cycles, want 1");
  endtask

  task automatic put(input logic [31:0] d, input logic [3:0] k, input logic f,
                     input logic l, input logic [15:0] len);
    int w;
    send(d, k, f, l, len, w);
  endtask

  task automatic idle();
    bus.udp_valid_in = 1'b0;
    bus.udp_first_in = 1'b0;
    bus.udp_last_in  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_srio);
    #1;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk_srio);
    cycles(3);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0, w, wsum;
    logic [31:0] b0, b1;
    bus.udp_data_in = '0; bus.udp_keep_in = '0; bus.udp_length_in = '0;
    idle();
    bus.srio_ready_in = 1'b1;
    reset_srio = 1'b1;
    #1;
    check("reset_outputs", {bus.srio_valid_out, bus.srio_first_out, bus.nwr_req_out,
                            bus.proto_err_out, bus.len_err_out}, 0);
    repeat (3) @(posedge clk_srio);
    #1 reset_srio = 1'b0;
    @(negedge clk_srio);
    check("ready_after_reset", bus.udp_ready_out, 1);
    cycles(1);

    // 4 full beats, length 16
    p0 = proto_cnt; l0 = len_cnt;
    expect_word(64'hA1A2A3A4_B1B2B3B4, 8'hFF, 1, 0, 16);
    expect_word(64'hC1C2C3C4_D1D2D3D4, 8'hFF, 0, 1, 16);
    put(32'hA1A2A3A4, 4'hF, 1, 0, 16);
    put(32'hB1B2B3B4, 4'hF, 0, 0, 16);
    put(32'hC1C2C3C4, 4'hF, 0, 0, 16);
    put(32'hD1D2D3D4, 4'hF, 0, 1, 16);
    idle();
    drain("s1_drain");
    check("s1_proto", proto_cnt - p0, 0);
    check("s1_len", len_cnt - l0, 0);

    // 3 beats, last keep 3, length 10
    p0 = proto_cnt; l0 = len_cnt;
    expect_word(64'h11111111_22222222, 8'hFF, 1, 0, 10);
    expect_word(64'h33333333_00000000, 8'h30, 0, 1, 10);
    put(32'h11111111, 4'hF, 1, 0, 10);
    put(32'h22222222, 4'hF, 0, 0, 10);
    put(32'h33333333, 4'h3, 0, 1, 10);
    idle();
    drain("s2_drain");
    check("s2_len", len_cnt - l0, 0);
    check("s2_proto", proto_cnt - p0, 0);

    // downstream stalled, 40 beats offered
    p0 = proto_cnt; l0 = len_cnt;
    bus.srio_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b0 = 32'h50000000 + 32'(2*i);
      b1 = 32'h50000000 + 32'(2*i + 1);
      expect_word({b0, b1}, 8'hFF, i == 0, i == 19, 160);
    end
    wsum = 0;
    for (int j = 0; j < 32; j++) begin
      send(32'h50000000 + 32'(j), 4'hF, j == 0, 0, 160, w);
      wsum += w;
    end
    check("s3_no_stall_before_full", wsum, 0);
    bus.udp_data_in = 32'h50000020; bus.udp_first_in = 1'b0; bus.udp_valid_in = 1'b1;
    repeat (4) @(negedge clk_srio);
    check("s3_ready_low_when_full", bus.udp_ready_out, 0);
    @(posedge clk_srio); #1;
    bus.srio_ready_in = 1'b1;
    for (int j = 32; j < 40; j++) put(32'h50000000 + 32'(j), 4'hF, 0, j == 39, 160);
    idle();
    drain("s3_drain");
    check("s3_len", len_cnt - l0, 0);

    // new first beat while one beat of a packet is pending
    p0 = proto_cnt; l0 = len_cnt;
    expect_word(64'hAAAA0001_00000000, 8'hF0, 1, 1, 8);
    expect_word(64'hBBBB0001_BBBB0002, 8'hFF, 1, 1, 8);
    put(32'hAAAA0001, 4'hF, 1, 0, 8);
    send(32'hBBBB0001, 4'hF, 1, 0, 8, w);
    check("s4_ready_low_cycles", w, 1);
    put(32'hBBBB0002, 4'hF, 0, 1, 8);
    idle();
    drain("s4_drain");
    check("s4_proto", proto_cnt - p0, 1);
    check("s4_len", len_cnt - l0, 0);

    // declared 20, actual 16
    p0 = proto_cnt; l0 = len_cnt;
    expect_word(64'h01020304_05060708, 8'hFF, 1, 0, 20);
    expect_word(64'h090A0B0C_0D0E0F10, 8'hFF, 0, 1, 20);
    put(32'h01020304, 4'hF, 1, 0, 20);
    put(32'h05060708, 4'hF, 0, 0, 20);
    put(32'h090A0B0C, 4'hF, 0, 0, 20);
    put(32'h0D0E0F10, 4'hF, 0, 1, 20);
    check("s5_len_err_next_cycle", bus.len_err_out, 1);
    idle();
    cycles(1);
    check("s5_len_err_one_cycle", bus.len_err_out, 0);
    drain("s5_drain");
    check("s5_len_pulses", len_cnt - l0, 1);
    check("s5_proto", proto_cnt - p0, 0);

    // beat without first while idle is dropped
    p0 = proto_cnt;
    put(32'hDEADBEEF, 4'hF, 0, 1, 4);
    idle();
    cycles(4);
    check("stray_proto", proto_cnt - p0, 1);

    // reset in the middle of a packet
    bus.srio_ready_in = 1'b0;
    put(32'h77770001, 4'hF, 1, 0, 12);
    put(32'h77770002, 4'hF, 0, 0, 12);
    put(32'h77770003, 4'hF, 0, 0, 12);
    idle();
    #1;
    check("s6_valid_before_reset", bus.srio_valid_out, 1);
    reset_srio = 1'b1;
    #1;
    check("s6_reset_ctrl", {bus.srio_valid_out, bus.srio_first_out, bus.srio_last_out,
                            bus.nwr_req_out, bus.proto_err_out, bus.len_err_out}, 0);
    check("s6_reset_data", bus.srio_data_out, 0);
    check("s6_reset_keep_len", {bus.srio_keep_out, bus.srio_length_out}, 0);
    @(posedge clk_srio); #1;
    reset_srio = 1'b0;
    bus.srio_ready_in = 1'b1;
    @(negedge clk_srio);
    check("s6_ready_after_reset", bus.udp_ready_out, 1);
    cycles(1);
    p0 = proto_cnt; l0 = len_cnt;
    expect_word(64'h88880001_88880002, 8'hFF, 1, 1, 8);
    put(32'h88880001, 4'hF, 1, 0, 8);
    put(32'h88880002, 4'hF, 0, 1, 8);
    idle();
    drain("s6_drain");
    check("s6_proto", proto_cnt - p0, 0);
    check("s6_len", len_cnt - l0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/udp_srio_width_packer.md
UDP_SRIO_WIDTH_PACKER -- requirements
Module: udp_srio_width_packer

Interface
REQ-001 The module SHALL have parameters, one per line: name, default, meaning.
- IN_WIDTH, 32, input beat width in bits; multiple of 8.
- OUT_WIDTH, 64, output word width; OUT_WIDTH/IN_WIDTH = N, power of two, N≥2.
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥4.
REQ-002 The module SHALL have one clock, clk_srio, and one asynchronous, active-high reset, reset_srio.
REQ-003 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk_srio  in  1  sole clock; all logic on rising edge.
- reset_srio  in  1  asynchronous, active-high reset.
- udp_data_in  in  IN_WIDTH  input beat data.
- udp_keep_in  in  IN_WIDTH/8  byte enables for the input beat.
- udp_valid_in  in  1  input beat valid.
- udp_first_in  in  1  first beat of a packet.
- udp_last_in  in  1  last beat of a packet.
- udp_length_in  in  16  declared packet byte count; sampled on the first beat.
- udp_ready_out  out  1  input beat accepted when high together with udp_valid_in.
- srio_ready_in  in  1  downstream ready.
- srio_data_out  out  OUT_WIDTH  packed word.
- srio_keep_out  out  OUT_WIDTH/8  packed byte enables.
- srio_valid_out  out  1  output word valid.
- srio_first_out  out  1  first word of a packet.
- srio_last_out  out  1  last word of a packet.
- srio_length_out  out  16  declared length; valid while srio_first_out is high.
- nwr_req_out  out  1  high when srio_valid_out and srio_first_out are both high.
- proto_err_out  out  1  one-cycle pulse on a framing error.
- len_err_out  out  1  one-cycle pulse on a length mismatch.

Function
REQ-004 Packing SHALL follow these rules.
- A beat is accepted when udp_valid_in and udp_ready_out are both high.
- Beat index k (0..N-1) within a word SHALL occupy data bits [OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] and the matching keep bits; the first beat is the MSB lane.
REQ-005 A word SHALL be written to the FIFO in the same cycle as the accepted beat that fills lane N-1 or carries udp_last_in; unfilled lanes SHALL carry data 0 and keep 0.
REQ-006 Each FIFO entry SHALL hold {data, keep, first, last, length}.
- first is set on the first word of a packet.
- length is the udp_length_in value captured on the first beat and SHALL travel with that word.
REQ-007 udp_ready_out SHALL equal NOT fifo_full, except where REQ-011 deasserts it.
REQ-008 The output SHALL be first-word-fall-through.
- srio_valid_out = NOT fifo_empty, with the outputs driven from the head entry.
- A pop occurs when srio_valid_out and srio_ready_in are both high.
- A word written at cycle t SHALL be visible at the output no earlier than t+1 when the FIFO was empty.
REQ-009 A simultaneous push and pop while full SHALL be allowed; the occupancy count SHALL stay in 0..FIFO_DEPTH with no overflow and no underflow.
REQ-010 The module SHALL keep state in_pkt: set on an accepted first beat, cleared on an accepted last beat. A single beat with first and last both set SHALL leave in_pkt clear.
REQ-011 First beat arriving while in_pkt is set:
- If the lane count is non-zero, the partial word SHALL be flushed with last=1 that cycle, udp_ready_out SHALL be low for that cycle, and proto_err_out SHALL pulse.
- The new beat SHALL be accepted in a later cycle at lane 0.
- If the lane count is zero, proto_err_out SHALL pulse and the new packet SHALL start normally with no flush.
REQ-012 An accepted beat without first while in_pkt is clear SHALL be discarded, and proto_err_out SHALL pulse.
REQ-013 Length check:
- A 17-bit byte counter SHALL add popcount(udp_keep_in) for each accepted beat of the packet.
- On the last beat, if the final sum differs from the captured length, len_err_out SHALL pulse in the next cycle.
- Packet data SHALL be forwarded unaltered either way.

Reset
REQ-014 Asserting reset_srio SHALL immediately clear the FIFO, the lane count, in_pkt, the byte counter and both error outputs.
REQ-015 While reset_srio is asserted, every srio_* output, nwr_req_out, proto_err_out and len_err_out SHALL be 0.
REQ-016 After reset_srio is released, udp_ready_out SHALL be 1.
REQ-017 A packet cut by reset SHALL be lost entirely; the next first beat SHALL start cleanly.

Verification (IN_WIDTH=32, OUT_WIDTH=64, FIFO_DEPTH=16)
REQ-018 The testbench SHALL cover at least these directed scenarios.
- 4 beats A,B,C,D, keep F, length 16 -> words {A,B} keep FF first=1 length=16 nwr_req=1, then {C,D} keep FF last=1; no error pulses.
- 3 beats, last keep 3, length 10 -> second word data {C,0} keep 30 last=1; len_err_out=0.
- srio_ready_in low, 40 beats offered -> udp_ready_out falls after 16 words are stored; after release, all words arrive in order with no loss or duplication.
- First beat after a single beat of an open packet -> word keep F0 last=1, proto_err_out pulses, udp_ready_out low for 1 cycle, and the new packet arrives intact.
- Declared length 20, actual 16 bytes -> len_err_out pulses once, the cycle after the last beat; data is still forwarded.
- reset_srio asserted mid-packet -> outputs go to 0 at once, without waiting for a clock edge; after release, the next packet is output correctly with first=1.
